ncl_fullword_counter_clk: RTL
=============================

# ncl_fullword_counter_clk

Parametrised, clocked, dual-rail counter with full-word completeness. It emits NULL/DATA wavefronts under a four-phase completion handshake. It generalises the fixed 32-bit self-timed counter ring to any width, and adds up, down, hold and load modes, a dual-rail carry/borrow-out and consumer back-pressure. It sits at the boundary where clocked test and control logic drives NCL datapaths that expect dual-rail wavefronts.

## Interface
- WIDTH, 32, counter width in bits; must be ≥1.
- INIT_VALUE, 0, count value after reset, truncated to WIDTH bits.

- clk  in  1  rising-edge clock.
- init_n  in  1  asynchronous active-low reset.
- ack_in  in  1  consumer completion. 1 = DATA received, request NULL. 0 = NULL received, request DATA.
- mode  in  2  next-count mode: 00 up, 01 down, 10 hold, 11 load.
- load_val  in  WIDTH  value used when mode=11.
- sum_t  out  WIDTH  true rails of the count.
- sum_f  out  WIDTH  false rails of the count.
- cout_t  out  1  true rail of carry/borrow-out.
- cout_f  out  1  false rail of carry/borrow-out.
- comp_out  out  1  full-word completeness: 1 while a DATA wavefront is presented, 0 while NULL.

## Operation
- Internal state:
  - phase FSM with states NULL_S and DATA_S.
  - cnt[WIDTH-1:0].
  - wrap flag.
- All outputs are registered.
- Reset value of every output and of the state, applied asynchronously while init_n=0:
  - sum_t=0, sum_f=0, cout_t=0, cout_f=0, comp_out=0.
  - phase=NULL_S, cnt=INIT_VALUE, wrap=0.
- NULL_S to DATA_S: on a rising edge with ack_in=0. The outputs switch in that edge to:
  - sum_t=cnt, sum_f=~cnt.
  - cout_t=wrap, cout_f=~wrap.
  - comp_out=1.
- DATA_S to NULL_S: on a rising edge with ack_in=1. In the same edge:
  - all rails go to 0 and comp_out goes to 0.
  - mode and load_val are sampled.
  - cnt and wrap update from the sampled mode.
- Update rules, all modulo 2^WIDTH:
  - up: cnt+1. wrap=1 only when cnt was all-ones.
  - down: cnt−1. wrap=1 only when cnt was 0.
  - hold: cnt unchanged, wrap=0.
  - load: cnt=load_val, wrap=0.
- mode and load_val are ignored on every other edge.
- Each DATA wavefront therefore carries the value produced by the previous update. The first wavefront after reset carries INIT_VALUE with cout_f=1.
- Full-word completeness invariants:
  - every rail pair changes in the same clock edge, never bit-serially.
  - sum_t&sum_f == 0 and cout_t&cout_f == 0 at all times.
  - in DATA_S, sum_t|sum_f is all-ones and cout_t|cout_f = 1.
- Back-pressure:
  - ack_in held 0 in DATA_S: the DATA wavefront and cnt stay stable indefinitely.
  - ack_in held 1 in NULL_S: outputs stay NULL indefinitely.
- ack_in=1 at reset release: the block stays NULL until ack_in=0 is sampled.
- Reset asserted mid-DATA: outputs return to NULL immediately, without waiting for a clock edge. Any pending update is discarded. After release, counting restarts from INIT_VALUE with wrap=0.

## Timing
- Latency from a sampled ack_in change to the output wavefront change is 1 clock edge.
- A DATA wavefront persists for at least 1 cycle. A NULL wavefront persists for at least 1 cycle.
- With ack_in=comp_out (combinational loopback), the maximum token rate is 1 DATA wavefront per 2 cycles.
- With ack_in driven from comp_out through one register, the rate is 1 token per 4 cycles.
- init_n deassertion is synchronised internally: the first state transition can occur on the second rising edge after release.
- cnt and wrap never change in DATA_S; they change only on the DATA_S to NULL_S edge.

## Test plan
- Reset and first token, WIDTH=4, INIT_VALUE=0:
  - stimulus: init_n=0, then release with ack_in=0.
  - during reset: all rails 0, comp_out=0.
  - second edge after release: sum_t=0000, sum_f=1111, cout_f=1, comp_out=1.
- Up-count wrap, WIDTH=4, ack_in=comp_out, mode=00:
  - DATA sequence: 0,1,…,15,0,1.
  - cout_t=1 only on the 0 that follows 15.
  - checker confirms exactly 2 cycles per token and no rail pair 11 at any time.
- Down borrow, WIDTH=4, mode=01 from reset:
  - DATA sequence: 0,15 (cout_t=1),14 (cout_f=1),13.
- Load and hold, WIDTH=8, counting up:
  - mode=11 with load_val=0xA5 on one DATA to NULL edge: next DATA is 0xA5 with cout_f=1.
  - mode=10: the following DATA is 0xA5 again.
  - mode=00: the next DATA is 0xA6.
- Back-pressure:
  - hold ack_in=0 for 10 cycles in DATA_S: output and cnt remain unchanged.
  - hold ack_in=1 for 10 cycles in NULL_S: all rails remain 0.
  - mode toggling during both stalls has no effect.
- Reset mid-operation, WIDTH=32, INIT_VALUE=0x7:
  - count to 0x20, then pulse init_n low between clock edges while in DATA_S.
  - rails clear before the next edge.
  - after release, the first DATA is 0x7 with cout_f=1.

Source files
------------

// File: rtl/ncl_fullword_counter_clk_if.sv
// Dual-rail counter wavefront bundle: completion ack and mode/load in; rails and completeness out.
// The counter side uses master; the NCL consumer/test side uses slave.
interface ncl_fullword_counter_clk_if #(
    parameter int WIDTH = 32
);
    logic             ack_in;
    logic [1:0]       mode;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] sum_t;
    logic [WIDTH-1:0] sum_f;
    logic             cout_t;
    logic             cout_f;
    logic             comp_out;

    modport master (
        input  ack_in, mode, load_val,
        output sum_t, sum_f, cout_t, cout_f, comp_out
    );

    modport slave (
        output ack_in, mode, load_val,
        input  sum_t, sum_f, cout_t, cout_f, comp_out
    );
endinterface

// File: rtl/ncl_fullword_counter_clk.sv
// Clocked dual-rail up/down/hold/load counter emitting full-word NULL/DATA wavefronts; 1-edge latency
// from a sampled ack_in change; ack_in stalls either phase indefinitely with rails and count frozen.
module ncl_fullword_counter_clk #(
    parameter int          WIDTH      = 32,
    parameter logic [63:0] INIT_VALUE = 64'd0
) (
    input  logic                        clk,
    input  logic                        init_n,
    ncl_fullword_counter_clk_if.master  bus
);
    localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT_VALUE);
    localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_HOLD = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic {NULL_S, DATA_S} phase_t;

    phase_t           r_phase;
    logic             r_run;
    logic [WIDTH-1:0] r_cnt;
    logic             r_wrap;
    logic [WIDTH-1:0] r_sum_t;
    logic [WIDTH-1:0] r_sum_f;
    logic             r_cout_t;
    logic             r_cout_f;
    logic             r_comp;

    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_wrap_nxt;

    // Reset release is retimed by one flop, so the earliest phase change is the second edge after release.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_wrap_nxt = 1'b0;
        case (bus.mode)
            MODE_UP: begin
                w_cnt_nxt  = r_cnt + ONE_W;
                w_wrap_nxt = &r_cnt;
            end
            MODE_DOWN: begin
                w_cnt_nxt  = r_cnt - ONE_W;
                w_wrap_nxt = ~|r_cnt;
            end
            MODE_HOLD: begin
                w_cnt_nxt  = r_cnt;
                w_wrap_nxt = 1'b0;
            end
            MODE_LOAD: begin
                w_cnt_nxt  = bus.load_val;
                w_wrap_nxt = 1'b0;
            end
        endcase
    end

    // Every rail pair is loaded in the same edge, so the word is always complete or always NULL.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_phase  <= NULL_S;
            r_cnt    <= INIT_W;
            r_wrap   <= 1'b0;
            r_sum_t  <= '0;
            r_sum_f  <= '0;
            r_cout_t <= 1'b0;
            r_cout_f <= 1'b0;
            r_comp   <= 1'b0;
        end else if (r_run) begin
            case (r_phase)
                NULL_S: begin
                    if (!bus.ack_in) begin
                        r_phase  <= DATA_S;
                        r_sum_t  <= r_cnt;
                        r_sum_f  <= ~r_cnt;
                        r_cout_t <= r_wrap;
                        r_cout_f <= ~r_wrap;
                        r_comp   <= 1'b1;
                    end
                end
                DATA_S: begin
                    if (bus.ack_in) begin
                        r_phase  <= NULL_S;
                        r_sum_t  <= '0;
                        r_sum_f  <= '0;
                        r_cout_t <= 1'b0;
                        r_cout_f <= 1'b0;
                        r_comp   <= 1'b0;
                        r_cnt    <= w_cnt_nxt;
                        r_wrap   <= w_wrap_nxt;
                    end
                end
                default: r_phase <= NULL_S;
            endcase
        end
    end

    assign bus.sum_t    = r_sum_t;
    assign bus.sum_f    = r_sum_f;
    assign bus.cout_t   = r_cout_t;
    assign bus.cout_f   = r_cout_f;
    assign bus.comp_out = r_comp;
endmodule
